// File: rtl/mutation.sv
// mutation -- mutation stage of the GA pipeline, directly after crossover.
//
// Takes the two children crossover produces each enabled cycle. For each child
// independently it flips at most one randomly chosen bit, with probability
// rate/256. The mutated pair goes on to the fitness input mux. The random
// source is an internal 32-bit Galois LFSR. Latency is fixed at two enabled
// cycles.
//
// Handshake: in_valid qualifies child1_in/child2_in on every edge where
// enable=1. out_valid qualifies mut1_out/mut2_out/flip1/flip2. There is no
// ready or back-pressure. The upstream sequencer stalls the stage by holding
// enable low, and that freezes every register, including the outputs and
// the LFSR.
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset
//   enable                advance pipeline and LFSR; low = full stall
//   in_valid              child pair valid this cycle
//   child1_in, child2_in  children from crossover (CHROM_W bits)
//   rate                  mutation probability * 256 (0 = never, >=256 = always)
//   seed                  LFSR seed, loaded while reset=1 (0 is replaced by 1)
//   out_valid             mutated pair valid
//   mut1_out, mut2_out    mutated children
//   flip1, flip2          a bit was flipped in the matching child
//   mut_count             saturating count of flips performed
//
// Configuration macro: MUT_STATS_EN. When it is defined, mut_count counts
// flips and saturates at 16'hFFFF. When it is undefined, mut_count is tied
// to 0.
module mutation #(
  parameter int CHROM_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               in_valid,
  input  logic [CHROM_W-1:0] child1_in,
  input  logic [CHROM_W-1:0] child2_in,
  input  logic [8:0]         rate,
  input  logic [31:0]        seed,
  output logic               out_valid,
  output logic [CHROM_W-1:0] mut1_out,
  output logic [CHROM_W-1:0] mut2_out,
  output logic               flip1,
  output logic               flip2,
  output logic [15:0]        mut_count
);

  localparam int          IW   = $clog2(CHROM_W);
  localparam logic [31:0] POLY = 32'h80200003;
  localparam logic [CHROM_W-1:0] ONE = {{(CHROM_W-1){1'b0}}, 1'b1};

  logic [31:0]        lfsr;
  logic [31:0]        lfsr_next;
  logic [7:0]         r1;
  logic [7:0]         r2;
  logic [IW-1:0]      i1;
  logic [IW-1:0]      i2;
  logic [CHROM_W-1:0] mask1_d;
  logic [CHROM_W-1:0] mask2_d;

  // Stage-1 registers
  logic               v1;
  logic [CHROM_W-1:0] c1;
  logic [CHROM_W-1:0] c2;
  logic [CHROM_W-1:0] mask1;
  logic [CHROM_W-1:0] mask2;

  // Galois right shift. The feedback mask contains bit 31, so a nonzero state
  // never shifts to zero. Reset replaces a zero seed, so the LFSR never
  // sticks at 0.
  always_comb begin
    lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0);
  end

  // Masks come from the current state, before this cycle's advance. The two
  // children use disjoint LFSR bytes for their decisions.
  always_comb begin
    r1      = lfsr[7:0];
    i1      = lfsr[8 +: IW];
    r2      = lfsr[23:16];
    i2      = lfsr[24 +: IW];
    mask1_d = '0;
    mask2_d = '0;
    if (in_valid && ({1'b0, r1} < rate)) mask1_d = ONE << i1;
    if (in_valid && ({1'b0, r2} < rate)) mask2_d = ONE << i2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= (seed == 32'h0) ? 32'h1 : seed;
      v1        <= 1'b0;
      c1        <= '0;
      c2        <= '0;
      mask1     <= '0;
      mask2     <= '0;
      out_valid <= 1'b0;
      mut1_out  <= '0;
      mut2_out  <= '0;
      flip1     <= 1'b0;
      flip2     <= 1'b0;
    end else if (enable) begin
      lfsr      <= lfsr_next;
      // Stage 1: data regs load even on bubbles; only v1 marks validity.
      v1        <= in_valid;
      c1        <= child1_in;
      c2        <= child2_in;
      mask1     <= mask1_d;
      mask2     <= mask2_d;
      // Stage 2
      out_valid <= v1;
      mut1_out  <= c1 ^ mask1;
      mut2_out  <= c2 ^ mask2;
      flip1     <= |mask1;
      flip2     <= |mask2;
    end
  end

`ifdef MUT_STATS_EN
  // Count from the stage-2 registers as they are presented. One extra sum bit
  // detects overflow, which then clamps the count at all-ones.
  logic [16:0] count_sum;

  always_comb begin
    count_sum = {1'b0, mut_count} + {16'h0, flip1} + {16'h0, flip2};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mut_count <= 16'h0;
    end else if (enable && out_valid) begin
      mut_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end
  end
`else
  assign mut_count = 16'h0;
`endif

endmodule
